sid_bus_if: RTL and testbench
=============================

SID_BUS_IF -- requirements
Module: sid_bus_if

Interface
REQ-001 Parameter DECAY_CYCLES, default 2048: clkEn ticks without a bus access before the bus latch decays to 0x00; legal range 1..65535.
REQ-002 clk  input  1  master clock; all state updates on posedge clk.
REQ-003 iRst  input  1  reset; synchronous, active-high; clock clk.
REQ-004 clkEn  input  1  1 MHz tick, one clk cycle wide; used only by the decay counter.
REQ-005 iReq  input  1  host access request; held high until oAck, then dropped.
REQ-006 iRW  input  1  1 = read, 0 = write; sampled with iReq.
REQ-007 iA  input  5  host register address 0x00-0x1F; sampled with iReq.
REQ-008 iD  input  8  host write data; sampled with iReq.
REQ-009 oAck  output  1  access complete; one clk cycle pulse.
REQ-010 oD  output  8  host read data; valid from the oAck cycle, held until the next read completes.
REQ-011 oWE  output  1  voice/register-file write strobe; one clk cycle pulse.
REQ-012 oAddr  output  5  register-file address; held stable from oWE assertion until the next accepted access.
REQ-013 oDataW  output  8  register-file write data; same stability rule as oAddr.
REQ-014 iPotX, iPotY, iOsc3, iEnv3  input  8 each  read sources for 0x19, 0x1A, 0x1B, 0x1C.

Function
REQ-015 FSM states: IDLE, WRITE, READ, ACK, RELEASE.
REQ-016 IDLE: iReq=1 at a posedge latches iRW, iA, iD, then moves to WRITE (iRW=0) or READ (iRW=1); iReq=0 keeps IDLE.
REQ-017 WRITE: oWE=1, oAddr=latched iA, oDataW=latched iD for exactly this cycle, then go to ACK.
REQ-018 READ: oD is loaded with the read mux value for the latched address, then go to ACK.
REQ-019 Read mux: 0x19 iPotX; 0x1A iPotY; 0x1B iOsc3; 0x1C iEnv3; 0x00-0x18 and 0x1D-0x1F return the bus latch.
REQ-020 ACK: oAck=1 for one cycle, then go to RELEASE.
REQ-021 RELEASE: stay while iReq=1, go to IDLE when iReq=0; no new request is accepted until iReq has been seen low.
REQ-022 Latency: request sampled at edge N gives oWE high in cycle N+1 (write) and oAck high in cycle N+2 (both directions).
REQ-023 Next access is accepted no earlier than 2 cycles after iReq falls.
REQ-024 Bus latch (8 bit) loads on a write in the WRITE cycle, and on a read of 0x19-0x1C with the returned value in the READ cycle; a read of any other address leaves it unchanged.
REQ-025 Decay counter (16 bit): cleared in every WRITE or READ cycle; otherwise increments on clkEn.
REQ-026 When the decay counter reaches DECAY_CYCLES, the bus latch is cleared to 0x00 and the counter saturates (no wrap).
REQ-027 A WRITE/READ cycle coinciding with clkEn: the clear and latch load win; no increment and no decay in that cycle.
REQ-028 A WRITE/READ cycle coinciding with the counter reaching terminal count: the latch load wins over decay.
REQ-029 oWE is never asserted outside WRITE; at most one oWE per request.
REQ-030 iA/iD/iRW changes after sampling have no effect on the access in progress.

Reset
REQ-031 iRst=1: state IDLE; oWE=0, oAck=0, oD=0x00, oAddr=0x00, oDataW=0x00, bus latch=0x00, decay counter=0.
REQ-032 iRst has priority over all state transitions; an access in progress is aborted with no oWE and no oAck, and the host must re-issue it.
REQ-033 The first request is accepted on the first posedge with iRst=0 and iReq=1.

Verification
REQ-034 Write iA=0x04, iD=0x41 -> oWE for exactly one cycle at N+1 with oAddr=0x04, oDataW=0x41; oAck at N+2; exactly one oWE.
REQ-035 iOsc3=0xA5, read 0x1B -> oD=0xA5 at oAck, N+2; then read 0x00 -> 0xA5 (latch).
REQ-036 DECAY_CYCLES=16: write 0x7F to 0x01, then read 0x1D after 15 clkEn -> 0x7F; after 16 clkEn -> 0x00.
REQ-037 Hold iReq high for 10 cycles after oAck -> single oAck and single oWE; a new request after iReq goes low is serviced normally.
REQ-038 Assert iRst during the WRITE cycle of a pending write -> no oAck, all outputs 0, latch 0x00; next request accepted right after reset is released.
REQ-039 Write coinciding with clkEn and decay terminal count -> latch holds the new data and counter=0.

Source files
------------

// File: rtl/sid_bus_if.sv
// sid_bus_if: host bus interface for the SID register file.
//
// Takes one host access at a time and runs it as a short sequence:
// IDLE -> WRITE or READ -> ACK -> RELEASE -> IDLE.
// It also keeps the data-bus latch, which clears to 0x00 after
// DECAY_CYCLES clkEn ticks with no bus access.
//
// Ports
//   clk            master clock; all state changes on its rising edge
//   iRst           synchronous, active-high reset
//   clkEn          1 MHz tick, one clk wide; drives only the decay counter
//   iReq           host request; held high until oAck, then dropped
//   iRW            1 = read, 0 = write; sampled with iReq
//   iA[4:0]        register address; sampled with iReq
//   iD[7:0]        write data; sampled with iReq
//   oAck           one-cycle access-complete pulse
//   oD[7:0]        read data; valid from oAck until the next read completes
//   oWE            one-cycle register-file write strobe
//   oAddr[4:0]     register-file address; stable until the next write is accepted
//   oDataW[7:0]    register-file write data; same stability as oAddr
//   iPotX/iPotY/iOsc3/iEnv3[7:0]  read sources for 0x19..0x1C
//
// state   | meaning
// IDLE    | waiting for iReq; samples iRW/iA/iD when it is seen
// WRITE   | oWE pulse, bus latch loaded with the write data
// READ    | oD loaded from the read mux
// ACK     | oAck pulse
// RELEASE | waiting for the host to drop iReq

module sid_bus_if #(
  parameter int DECAY_CYCLES = 2048
) (
  input  logic       clk,
  input  logic       iRst,
  input  logic       clkEn,
  input  logic       iReq,
  input  logic       iRW,
  input  logic [4:0] iA,
  input  logic [7:0] iD,
  output logic       oAck,
  output logic [7:0] oD,
  output logic       oWE,
  output logic [4:0] oAddr,
  output logic [7:0] oDataW,
  input  logic [7:0] iPotX,
  input  logic [7:0] iPotY,
  input  logic [7:0] iOsc3,
  input  logic [7:0] iEnv3
);

  localparam logic [15:0] DECAY_TC = 16'(DECAY_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_ACK,
    S_RELEASE
  } state_t;

  state_t      state, state_nx;
  logic [4:0]  addr_q;
  logic [7:0]  bus_latch;
  logic [15:0] decay_cnt;
  logic [7:0]  rd_mux;
  logic        rd_live;

  // Only the four live read sources refresh the bus latch; every other
  // address returns whatever is still on the bus.
  always_comb begin
    rd_mux  = bus_latch;
    rd_live = 1'b1;
    case (addr_q)
      5'h19:   rd_mux = iPotX;
      5'h1A:   rd_mux = iPotY;
      5'h1B:   rd_mux = iOsc3;
      5'h1C:   rd_mux = iEnv3;
      default: rd_live = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = state;
    oWE      = 1'b0;
    oAck     = 1'b0;
    case (state)
      S_IDLE: begin
        if (iReq) state_nx = iRW ? S_READ : S_WRITE;
      end
      S_WRITE: begin
        oWE      = 1'b1;
        state_nx = S_ACK;
      end
      S_READ: begin
        state_nx = S_ACK;
      end
      S_ACK: begin
        oAck     = 1'b1;
        state_nx = S_RELEASE;
      end
      S_RELEASE: begin
        if (!iReq) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    // Reset aborts the access in flight: the strobes are suppressed in the
    // very cycle reset is asserted, not one cycle later.
    if (iRst) begin
      oWE  = 1'b0;
      oAck = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (iRst) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      oD        <= '0;
      oAddr     <= '0;
      oDataW    <= '0;
      bus_latch <= '0;
      decay_cnt <= '0;
    end else begin
      state <= state_nx;

      // oAddr/oDataW are only touched when a write is accepted, so they
      // stay stable across reads and idle periods.
      if (state == S_IDLE && iReq) begin
        addr_q <= iA;
        if (!iRW) begin
          oAddr  <= iA;
          oDataW <= iD;
        end
      end

      if (state == S_READ) oD <= rd_mux;

      // A bus access beats both the clkEn increment and decay.
      if (state == S_WRITE) begin
        bus_latch <= oDataW;
        decay_cnt <= '0;
      end else if (state == S_READ) begin
        if (rd_live) bus_latch <= rd_mux;
        decay_cnt <= '0;
      end else if (clkEn && decay_cnt != DECAY_TC) begin
        decay_cnt <= decay_cnt + 16'd1;
        if (decay_cnt + 16'd1 == DECAY_TC) bus_latch <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sid_bus_if.sv
// tb_sid_bus_if: bench for sid_bus_if with DECAY_CYCLES=16.
// Host accesses push their expected outcome into a queue; a negedge monitor
// pops it on oAck and checks oWE/oAddr/oDataW/oD against it.

module tb_sid_bus_if;

  logic       clk = 1'b0;
  logic       iRst;
  logic       clkEn;
  logic       iReq;
  logic       iRW;
  logic [4:0] iA;
  logic [7:0] iD;
  logic       oAck;
  logic [7:0] oD;
  logic       oWE;
  logic [4:0] oAddr;
  logic [7:0] oDataW;
  logic [7:0] iPotX, iPotY, iOsc3, iEnv3;

  int checks   = 0;
  int failures = 0;
  int we_total = 0;
  int ack_total = 0;
  int writes_issued = 0;
  int accesses_issued = 0;
  int we_in_txn = 0;

  typedef struct {
    logic       rw;
    logic [4:0] a;
    logic [7:0] d;
  } exp_t;

  exp_t exp_q[$];

  sid_bus_if #(.DECAY_CYCLES(16)) dut (
    .clk(clk), .iRst(iRst), .clkEn(clkEn), .iReq(iReq), .iRW(iRW),
    .iA(iA), .iD(iD), .oAck(oAck), .oD(oD), .oWE(oWE), .oAddr(oAddr),
    .oDataW(oDataW), .iPotX(iPotX), .iPotY(iPotY), .iOsc3(iOsc3),
    .iEnv3(iEnv3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (oWE) begin
      we_total++;
      if (exp_q.size() == 0 || exp_q[0].rw) begin
        chk("we_unexpected", 16'd1, 16'd0);
      end else begin
        chk("we_addr", 16'(oAddr), 16'(exp_q[0].a));
        chk("we_data", 16'(oDataW), 16'(exp_q[0].d));
        we_in_txn++;
      end
    end
    if (oAck) begin
      ack_total++;
      if (exp_q.size() == 0) begin
        chk("ack_unexpected", 16'd1, 16'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.rw) begin
          chk("rd_data", 16'(oD), 16'(e.d));
          chk("rd_no_we", 16'(we_in_txn), 16'd0);
        end else begin
          chk("wr_one_we", 16'(we_in_txn), 16'd1);
        end
        we_in_txn = 0;
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      clkEn = 1'b1;
      @(posedge clk); #1;
      clkEn = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  // Called #1 after a posedge with the DUT in IDLE; returns with it in IDLE.
  task automatic access(input logic rw, input logic [4:0] a, input logic [7:0] d,
                        input int hold, input logic ce_in_access);
    exp_t e;
    e.rw = rw; e.a = a; e.d = d;
    exp_q.push_back(e);
    accesses_issued++;
    if (!rw) writes_issued++;
    iReq = 1'b1; iRW = rw; iA = a; iD = d;
    @(posedge clk); #1;
    // Scramble the sampled inputs: the access in flight must ignore them.
    iRW = ~rw; iA = ~a; iD = ~d;
    if (ce_in_access) clkEn = 1'b1;
    chk("we_at_n1", 16'(oWE), 16'(!rw));
    chk("ack_at_n1", 16'(oAck), 16'd0);
    @(posedge clk); #1;
    clkEn = 1'b0;
    chk("ack_at_n2", 16'(oAck), 16'd1);
    chk("we_at_n2", 16'(oWE), 16'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("ack_hold", 16'(oAck), 16'd0);
    end
    iReq = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    iRst = 1'b1; clkEn = 1'b0; iReq = 1'b0; iRW = 1'b0; iA = '0; iD = '0;
    iPotX = 8'h00; iPotY = 8'h00; iOsc3 = 8'h00; iEnv3 = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", 16'(oWE), 16'd0);
    chk("rst_ack", 16'(oAck), 16'd0);
    chk("rst_od", 16'(oD), 16'd0);
    chk("rst_addr", 16'(oAddr), 16'd0);
    chk("rst_dataw", 16'(oDataW), 16'd0);

    // First request presented together with reset release.
    iRst = 1'b0;
    access(1'b0, 5'h04, 8'h41, 0, 1'b0);
    chk("addr_held", 16'(oAddr), 16'h04);
    chk("dataw_held", 16'(oDataW), 16'h41);
    access(1'b1, 5'h00, 8'h41, 0, 1'b0);

    iOsc3 = 8'hA5;
    access(1'b1, 5'h1B, 8'hA5, 0, 1'b0);
    access(1'b1, 5'h00, 8'hA5, 0, 1'b0);
    iPotX = 8'h3C; iPotY = 8'h5A; iEnv3 = 8'h96;
    access(1'b1, 5'h19, 8'h3C, 0, 1'b0);
    access(1'b1, 5'h1A, 8'h5A, 0, 1'b0);
    access(1'b1, 5'h1C, 8'h96, 0, 1'b0);
    access(1'b1, 5'h1F, 8'h96, 0, 1'b0);
    chk("addr_after_reads", 16'(oAddr), 16'h04);

    // Decay: 15 ticks keep the latch, 16 clear it.
    access(1'b0, 5'h01, 8'h7F, 0, 1'b0);
    tick(15);
    access(1'b1, 5'h1D, 8'h7F, 0, 1'b0);
    tick(16);
    access(1'b1, 5'h1D, 8'h00, 0, 1'b0);
    tick(3);
    access(1'b1, 5'h1D, 8'h00, 0, 1'b0);

    // Write cycle coincides with clkEn at the terminal count.
    access(1'b0, 5'h02, 8'h33, 0, 1'b0);
    tick(15);
    access(1'b0, 5'h03, 8'hC8, 0, 1'b1);
    tick(15);
    access(1'b1, 5'h1D, 8'hC8, 0, 1'b0);

    // iReq held 10 cycles after oAck.
    access(1'b0, 5'h05, 8'h11, 10, 1'b0);
    access(1'b1, 5'h05, 8'h11, 0, 1'b0);

    // Reset asserted during the WRITE cycle of a pending write.
    iReq = 1'b1; iRW = 1'b0; iA = 5'h06; iD = 8'hEE;
    @(posedge clk); #1;
    iRst = 1'b1;
    #1;
    chk("abort_we", 16'(oWE), 16'd0);
    @(posedge clk); #1;
    iReq = 1'b0;
    chk("abort_ack", 16'(oAck), 16'd0);
    chk("abort_we2", 16'(oWE), 16'd0);
    chk("abort_od", 16'(oD), 16'd0);
    chk("abort_addr", 16'(oAddr), 16'd0);
    chk("abort_dataw", 16'(oDataW), 16'd0);
    @(posedge clk); #1;
    iRst = 1'b0;
    access(1'b1, 5'h00, 8'h00, 0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("we_total", 16'(we_total), 16'(writes_issued));
    chk("ack_total", 16'(ack_total), 16'(accesses_issued));
    chk("queue_empty", 16'(exp_q.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
